// File: rtl/ami_r_split.sv
// ami_r_split: AXI master read splitter, user request -> 4KB-safe INCR bursts.
// Optional AMI_R_RESP_MERGE_EN: usr_rresp carries the running worst RRESP of a request.
module ami_r_split #(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int ULW    = 12,
  parameter int BL     = 16,
  parameter int AMI_OD = 4,
  parameter int AMI_RD = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  output logic [AXI_IW-1:0] ARID,
  output logic [AXI_AW-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [AXI_IW-1:0] RID,
  input  logic [AXI_DW-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [AXI_IW-1:0] usr_arid,
  input  logic [AXI_AW-1:0] usr_araddr,
  input  logic [ULW-1:0]    usr_arlen,
  input  logic              usr_arvalid,
  output logic              usr_arready,
  output logic [AXI_IW-1:0] usr_rid,
  output logic [AXI_DW-1:0] usr_rdata,
  output logic [1:0]        usr_rresp,
  output logic              usr_rlast,
  output logic              usr_rvalid,
  input  logic              usr_rready
);

  localparam int L   = $clog2(AXI_DW / 8);
  localparam int BW  = $clog2(BL + 1);
  localparam int RW  = $clog2(AMI_RD + 1);
  localparam int OW  = $clog2(AMI_OD + 1);
  localparam int TW  = (AMI_OD > 1) ? $clog2(AMI_OD) : 1;
  localparam int PW  = (AMI_RD > 1) ? $clog2(AMI_RD) : 1;
  localparam int CW  = (ULW + 2 > 14) ? ULW + 2 : 14;
  localparam int EW  = AXI_IW + AXI_DW + 3;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_live;
  logic [AXI_IW-1:0]  r_id;
  logic [AXI_AW-1:0]  r_addr;
  logic [ULW:0]       r_rem;
  logic [BW-1:0]      r_beats;
  logic [7:0]         r_arlen;
  logic               r_last;
  logic [OW-1:0]      r_ost;
  logic [RW-1:0]      r_resv;
  logic [AXI_IW:0]    r_tag [AMI_OD];
  logic [TW-1:0]      r_twp, r_trp;
  logic [EW-1:0]      r_mem [AMI_RD];
  logic [PW-1:0]      r_bwp, r_brp;
  logic [RW-1:0]      r_bcnt;

  logic               w_req_hs, w_ar_hs, w_rhs, w_rlast_hs, w_pop, w_credit;
  logic [12:0]        w_span;
  logic [CW-1:0]      w_to4k, w_rem_c, w_min;
  logic [AXI_IW:0]    w_tag;
  logic [EW-1:0]      w_head;
  logic [1:0]         w_hresp;
  logic               w_unused_rid;

  function automatic logic [TW-1:0] f_tinc(input logic [TW-1:0] p);
    return (p == TW'(AMI_OD - 1)) ? '0 : p + TW'(1);
  endfunction

  function automatic logic [PW-1:0] f_binc(input logic [PW-1:0] p);
    return (p == PW'(AMI_RD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_unused_rid = ^RID;

  assign w_credit = (r_ost < OW'(AMI_OD)) &&
                    (({1'b0, r_resv} + (RW+1)'(r_beats)) <= (RW+1)'(AMI_RD));

  assign ARVALID     = (r_state == S_ISSUE) && w_credit;
  assign ARID        = r_id;
  assign ARADDR      = r_addr;
  assign ARLEN       = r_arlen;
  assign ARSIZE      = 3'(L);
  assign ARBURST     = 2'b01;
  assign usr_arready = (r_state == S_IDLE) && r_live;

  assign w_req_hs   = usr_arvalid && usr_arready;
  assign w_ar_hs    = ARVALID && ARREADY;
  assign w_rhs      = RVALID && RREADY;
  assign w_rlast_hs = w_rhs && RLAST;
  assign w_pop      = usr_rvalid && usr_rready;

  assign w_tag   = r_tag[r_trp];
  assign w_head  = r_mem[r_brp];
  assign w_hresp = w_head[2:1];

  assign RREADY     = (r_bcnt != RW'(AMI_RD));
  assign usr_rvalid = (r_bcnt != '0);
  assign usr_rid    = w_head[EW-1 -: AXI_IW];
  assign usr_rdata  = w_head[AXI_DW+2:3];
  assign usr_rlast  = usr_rvalid && w_head[0];

  // Burst size: stop at the remaining count, BL, or the next 4KB page
  always_comb begin
    w_span  = 13'h1000 - {1'b0, r_addr[11:0]};
    w_to4k  = CW'(w_span >> L);
    w_rem_c = CW'(r_rem);
    w_min   = w_rem_c;
    if (CW'(BL) < w_min) w_min = CW'(BL);
    if (w_to4k < w_min) w_min = w_to4k;
  end

  // Next-state logic of the request splitter
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req_hs) w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_ar_hs) w_state_nxt = r_last ? S_IDLE : S_CALC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; r_live keeps usr_arready low while in reset
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  // Request tracking: latch on accept, advance on each AR handshake
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_beats <= '0;
      r_arlen <= '0;
      r_last  <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_id   <= usr_arid;
        r_addr <= usr_araddr;
        r_rem  <= {1'b0, usr_arlen} + (ULW+1)'(1);
      end else if (w_ar_hs) begin
        r_addr <= r_addr + (AXI_AW'(r_beats) << L);
        r_rem  <= r_rem - (ULW+1)'(r_beats);
      end
      if (r_state == S_CALC) begin
        r_beats <= BW'(w_min);
        r_arlen <= 8'(w_min - CW'(1));
        r_last  <= (w_min == w_rem_c);
      end
    end
  end

  // Credit counters; AR issue and R return deltas combine in one cycle
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ost  <= '0;
      r_resv <= '0;
      r_bcnt <= '0;
    end else begin
      r_ost  <= r_ost + OW'(w_ar_hs) - OW'(w_rlast_hs);
      r_resv <= r_resv + (w_ar_hs ? RW'(r_beats) : '0) - RW'(w_pop);
      r_bcnt <= r_bcnt + RW'(w_rhs) - RW'(w_pop);
    end
  end

  // Tag FIFO and R buffer pointers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_twp <= '0;
      r_trp <= '0;
      r_bwp <= '0;
      r_brp <= '0;
    end else begin
      if (w_ar_hs)    r_twp <= f_tinc(r_twp);
      if (w_rlast_hs) r_trp <= f_tinc(r_trp);
      if (w_rhs)      r_bwp <= f_binc(r_bwp);
      if (w_pop)      r_brp <= f_binc(r_brp);
    end
  end

  // Storage writes; slots are only read once their pointer covers them
  always_ff @(posedge ACLK) begin
    if (w_ar_hs) r_tag[r_twp] <= {r_id, r_last};
    if (w_rhs)   r_mem[r_bwp] <= {w_tag[AXI_IW:1], RDATA, RRESP, RLAST & w_tag[0]};
  end

`ifdef AMI_R_RESP_MERGE_EN
  logic [1:0] r_worst;
  logic [1:0] w_merged;

  assign w_merged  = (w_hresp > r_worst) ? w_hresp : r_worst;
  assign usr_rresp = w_merged;

  // Sticky worst response, cleared after the request's last beat leaves
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_worst <= 2'b00;
    else if (w_pop) r_worst <= w_head[0] ? 2'b00 : w_merged;
  end
`else
  assign usr_rresp = w_hresp;
`endif

endmodule

// File: tb/tb_ami_r_split.sv
// tb_ami_r_split: scoreboard bench for ami_r_split.
// Directed requests with an AXI slave model and hand-listed AR bursts.
`timescale 1ns/1ps
module tb_ami_r_split;
  localparam int DW  = 128;
  localparam int AW  = 32;
  localparam int IW  = 8;
  localparam int ULW = 12;
  localparam int BL  = 16;
  localparam int OD  = 2;
  localparam int RD  = 32;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [IW-1:0] ARID;
  logic [AW-1:0] ARADDR;
  logic [7:0] ARLEN;
  logic [2:0] ARSIZE;
  logic [1:0] ARBURST;
  logic ARVALID, ARREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0] RRESP;
  logic RLAST, RVALID, RREADY;
  logic [IW-1:0] usr_arid;
  logic [AW-1:0] usr_araddr;
  logic [ULW-1:0] usr_arlen;
  logic usr_arvalid, usr_arready;
  logic [IW-1:0] usr_rid;
  logic [DW-1:0] usr_rdata;
  logic [1:0] usr_rresp;
  logic usr_rlast, usr_rvalid, usr_rready;

  ami_r_split #(
    .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .ULW(ULW),
    .BL(BL), .AMI_OD(OD), .AMI_RD(RD)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .usr_arid(usr_arid), .usr_araddr(usr_araddr), .usr_arlen(usr_arlen),
    .usr_arvalid(usr_arvalid), .usr_arready(usr_arready),
    .usr_rid(usr_rid), .usr_rdata(usr_rdata), .usr_rresp(usr_rresp),
    .usr_rlast(usr_rlast), .usr_rvalid(usr_rvalid), .usr_rready(usr_rready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0] resp;
    logic last;
  } beat_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0] len;
  } ar_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0] len;
    int stamp;
  } sar_t;

  beat_t exp_q[$];
  ar_t exp_ar[$];
  sar_t sq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ar_cnt = 0;
  int rl_cnt = 0;
  int r_delay = 0;
  logic [AW-1:0] err_addr = 32'hFFFF_FFFF;

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'h1234_5678};
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // AR monitor: compare against the hand-listed bursts, feed the slave
  ar_t m_ar;
  sar_t m_s;
  always @(negedge ACLK) begin
    if (!ARESET && ARVALID && ARREADY) begin
      chk((ar_cnt - rl_cnt) < OD, "ost_limit", ar_cnt - rl_cnt, OD - 1);
      if (exp_ar.size() == 0) begin
        chk(1'b0, "ar_unexpected", ARADDR, 0);
      end else begin
        m_ar = exp_ar.pop_front();
        chk(ARADDR == m_ar.addr && ARLEN == m_ar.len && ARID == m_ar.id &&
            ARSIZE == 3'd4 && ARBURST == 2'b01, "ar_fields",
            {ARID, ARADDR, ARLEN, ARSIZE, ARBURST},
            {m_ar.id, m_ar.addr, m_ar.len, 3'd4, 2'b01});
      end
      m_s.addr = ARADDR;
      m_s.len = ARLEN;
      m_s.stamp = cyc;
      sq.push_back(m_s);
      ar_cnt++;
    end
  end

  // User R monitor: pop the scoreboard on every delivered beat
  beat_t m_b;
  always @(negedge ACLK) begin
    if (!ARESET && usr_rvalid && usr_rready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "r_unexpected", usr_rdata, 0);
      end else begin
        m_b = exp_q.pop_front();
        chk(usr_rdata == m_b.data, "r_data", usr_rdata, m_b.data);
        chk(usr_rid == m_b.id && usr_rresp == m_b.resp && usr_rlast == m_b.last,
            "r_id_resp_last", {usr_rid, usr_rresp, usr_rlast},
            {m_b.id, m_b.resp, m_b.last});
      end
    end
  end

  // AXI slave R channel: in-order bursts after r_delay cycles
  initial begin : slave_r
    logic fire;
    logic act;
    logic [AW-1:0] a;
    int left;
    sar_t s;
    act = 1'b0;
    a = '0;
    left = 0;
    RVALID = 1'b0;
    RLAST = 1'b0;
    RDATA = '0;
    RRESP = 2'b00;
    RID = '0;
    forever begin
      @(negedge ACLK);
      fire = RVALID && RREADY && !ARESET;
      if (RVALID && !ARESET) chk(RREADY === 1'b1, "rready_high", RREADY, 1);
      @(posedge ACLK);
      #1;
      if (ARESET) begin
        act = 1'b0;
        sq.delete();
        RVALID = 1'b0;
        RLAST = 1'b0;
      end else begin
        if (fire) begin
          if (RLAST) rl_cnt++;
          a = a + 32'd16;
          left--;
          if (left == 0) act = 1'b0;
        end
        if (!act && sq.size() > 0 && cyc >= sq[0].stamp + r_delay) begin
          s = sq.pop_front();
          act = 1'b1;
          a = s.addr;
          left = int'(s.len) + 1;
        end
        RVALID = act;
        RLAST = act && (left == 1);
        RDATA = pat(a);
        RRESP = (a == err_addr) ? 2'd2 : 2'd0;
      end
    end
  end

  task automatic push_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len);
    ar_t e;
    e.id = id;
    e.addr = addr;
    e.len = len;
    exp_ar.push_back(e);
  endtask

  task automatic req(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                     input logic [ULW-1:0] len);
    int n;
    logic [1:0] stick;
    stick = 2'd0;
    for (int i = 0; i <= int'(len); i++) begin
      beat_t b;
      logic [AW-1:0] ba;
      logic [1:0] r;
      ba = addr + AW'(i * 16);
      r = (ba == err_addr) ? 2'd2 : 2'd0;
`ifdef AMI_R_RESP_MERGE_EN
      if (r > stick) stick = r;
      r = stick;
`endif
      b.id = id;
      b.data = pat(ba);
      b.resp = r;
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
    @(posedge ACLK);
    #1;
    usr_arvalid = 1'b1;
    usr_arid = id;
    usr_araddr = addr;
    usr_arlen = len;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!usr_arready && n < 5000);
    chk(usr_arready, "req_accept", usr_arready, 1);
    @(posedge ACLK);
    #1;
    usr_arvalid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || exp_ar.size() > 0) && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    chk(exp_q.size() == 0 && exp_ar.size() == 0, "drain",
        {exp_q.size(), exp_ar.size()}, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int base;
    ARREADY = 1'b1;
    usr_rready = 1'b1;
    usr_arvalid = 1'b0;
    usr_arid = '0;
    usr_araddr = '0;
    usr_arlen = '0;

    repeat (3) @(negedge ACLK);
    chk(ARVALID == 1'b0, "rst_arvalid", ARVALID, 0);
    chk(usr_arready == 1'b0, "rst_usr_arready", usr_arready, 0);
    chk(usr_rvalid == 1'b0, "rst_usr_rvalid", usr_rvalid, 0);
    chk(usr_rlast == 1'b0, "rst_usr_rlast", usr_rlast, 0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    chk(usr_arready == 1'b1, "arready_after_reset", usr_arready, 1);

    // 4KB crossing split
    push_ar(8'h11, 32'h0000_0F80, 8'd7);
    push_ar(8'h11, 32'h0000_1000, 8'd15);
    push_ar(8'h11, 32'h0000_1100, 8'd15);
    push_ar(8'h11, 32'h0000_1200, 8'd15);
    push_ar(8'h11, 32'h0000_1300, 8'd7);
    req(8'h11, 32'h0000_0F80, 12'd63);
    drain(2000);

    // single beat, latency and arready return
    push_ar(8'h22, 32'h0000_2000, 8'd0);
    req(8'h22, 32'h0000_2000, 12'd0);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!(ARVALID && ARREADY) && n < 20);
    chk(n == 2, "ar_latency", n, 2);
    @(negedge ACLK);
    chk(usr_arready == 1'b1, "arready_after_last_ar", usr_arready, 1);
    drain(200);

    // address wrap at top of memory
    push_ar(8'h33, 32'hFFFF_FFE0, 8'd1);
    push_ar(8'h33, 32'h0000_0000, 8'd1);
    req(8'h33, 32'hFFFF_FFE0, 12'd3);
    drain(200);

    // R-buffer credit limit with user stalled
    usr_rready = 1'b0;
    for (int i = 0; i < 4; i++) push_ar(8'h44, AW'(i * 256), 8'd15);
    base = ar_cnt;
    req(8'h44, 32'h0000_0000, 12'd63);
    repeat (80) @(negedge ACLK);
    chk(ar_cnt - base == 2, "rd_limit_ars", ar_cnt - base, 2);
    chk(ARVALID == 1'b0, "rd_limit_arvalid_low", ARVALID, 0);
    @(posedge ACLK);
    #1;
    usr_rready = 1'b1;
    repeat (16) @(posedge ACLK);
    #1;
    usr_rready = 1'b0;
    chk(exp_q.size() == 48, "rd_pops", exp_q.size(), 48);
    repeat (40) @(negedge ACLK);
    chk(ar_cnt - base == 3, "rd_third_ar", ar_cnt - base, 3);
    usr_rready = 1'b1;
    drain(1000);

    // outstanding limit with slow slave
    r_delay = 50;
    for (int i = 0; i < 4; i++) push_ar(8'h55, 32'h0000_4000 + AW'(i * 256), 8'd15);
    base = ar_cnt;
    req(8'h55, 32'h0000_4000, 12'd63);
    repeat (30) @(negedge ACLK);
    chk(ar_cnt - base == 2, "od_two_ars", ar_cnt - base, 2);
    drain(2000);
    r_delay = 0;

    // ARREADY stall: AR fields hold
    ARREADY = 1'b0;
    push_ar(8'h66, 32'h0000_5000, 8'd15);
    push_ar(8'h66, 32'h0000_5100, 8'd15);
    req(8'h66, 32'h0000_5000, 12'd31);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!ARVALID && n < 20);
    chk(ARVALID == 1'b1, "stall_arvalid_rise", ARVALID, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk(ARVALID && ARADDR == 32'h0000_5000 && ARLEN == 8'd15, "stall_hold",
          {ARVALID, ARADDR, ARLEN}, {1'b1, 32'h0000_5000, 8'd15});
    end
    ARREADY = 1'b1;
    drain(500);

    // error response on beat 5 of 8, then a clean request
    err_addr = 32'h0000_6040;
    push_ar(8'h77, 32'h0000_6000, 8'd7);
    req(8'h77, 32'h0000_6000, 12'd7);
    drain(300);
    err_addr = 32'hFFFF_FFFF;
    push_ar(8'h78, 32'h0000_6100, 8'd3);
    req(8'h78, 32'h0000_6100, 12'd3);
    drain(300);

    // maximum request length
    for (int i = 0; i < 256; i++) push_ar(8'h88, 32'h0001_0000 + AW'(i * 256), 8'd15);
    req(8'h88, 32'h0001_0000, 12'hFFF);
    drain(20000);

    // reset in the middle of a request
    usr_rready = 1'b0;
    for (int i = 0; i < 4; i++) push_ar(8'h99, 32'h0000_7000 + AW'(i * 256), 8'd15);
    req(8'h99, 32'h0000_7000, 12'd63);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!usr_rvalid && n < 100);
    ARREADY = 1'b0;
    usr_rready = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!ARVALID && n < 100);
    chk(ARVALID == 1'b1 && usr_rvalid == 1'b1, "pre_reset_busy",
        {ARVALID, usr_rvalid}, 2'b11);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    #1;
    chk(ARVALID == 1'b0, "midrst_arvalid", ARVALID, 0);
    chk(usr_rvalid == 1'b0, "midrst_usr_rvalid", usr_rvalid, 0);
    chk(usr_arready == 1'b0, "midrst_usr_arready", usr_arready, 0);
    repeat (3) @(negedge ACLK);
    exp_q.delete();
    exp_ar.delete();
    ar_cnt = 0;
    rl_cnt = 0;
    ARREADY = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    chk(usr_arready == 1'b1, "arready_after_mid_reset", usr_arready, 1);
    push_ar(8'hAA, 32'h0000_8000, 8'd3);
    req(8'hAA, 32'h0000_8000, 12'd3);
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ami_r_split.md
Name: ami_r_split

Overview:
- Next-generation single-clock AXI master read interface.
- Accepts one user read request of up to 2^ULW beats and splits it into AXI INCR bursts. Each burst is at most BL beats and never crosses a 4 KB boundary.
- Issues a burst only when R-buffer space for all its beats is reserved, so RVALID is never back-pressured. Returns data to the user with a single usr_rlast per request.
- Sits between a DMA-style user engine and the AXI interconnect in the ACLK domain; no CDC.

Parameters:
AXI_DW, 128, data bus width; AXI_BYTES=AXI_DW/8, L=log2(AXI_BYTES)
AXI_AW, 32, address width
AXI_IW, 8, ID width
ULW, 12, user length width (usr_arlen = beats-1)
BL, 16, max beats per AXI burst (power of 2, <=256)
AMI_OD, 4, max outstanding AXI bursts
AMI_RD, 64, R buffer depth in beats (>=BL)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
ARID  out  AXI_IW  = latched usr_arid for all sub-bursts
ARADDR  out  AXI_AW  sub-burst start address
ARLEN  out  8  sub-burst beats-1
ARSIZE  out  3  constant L
ARBURST  out  2  constant 2'b01 (INCR)
ARVALID  out  1  AR valid
ARREADY  in  1  AR ready
RID  in  AXI_IW  ignored (single ID, in order)
RDATA  in  AXI_DW  read data
RRESP  in  2  read response
RLAST  in  1  sub-burst last
RVALID  in  1  R valid
RREADY  out  1  = !rbuf_full
usr_arid  in  AXI_IW  request ID
usr_araddr  in  AXI_AW  start address, AXI_BYTES-aligned
usr_arlen  in  ULW  total beats-1
usr_arvalid  in  1  request valid
usr_arready  out  1  request ready
usr_rid  out  AXI_IW  request ID
usr_rdata  out  AXI_DW  data
usr_rresp  out  2  response
usr_rlast  out  1  last beat of whole request
usr_rvalid  out  1  = !rbuf_empty
usr_rready  in  1  user ready

Behaviour:
- Reset (ARESET=1, async): ARVALID=0, usr_arready=0, usr_rvalid=0, usr_rlast=0; all counters, buffers and tag FIFO cleared; FSM=IDLE. Mid-operation reset discards all state; the bench must also reset the slave.
- FSM IDLE:
  - usr_arready=1.
  - On usr_arvalid&usr_arready: latch id, addr, rem=usr_arlen+1 (ULW+1 bits); go to CALC.
- FSM CALC (1 cycle):
  - to4k=(4096-addr[11:0])>>L.
  - beats=min(rem,BL,to4k).
  - Register ARADDR=addr, ARLEN=beats-1, last_flag=(beats==rem).
  - Go to ISSUE.
- FSM ISSUE:
  - Raise ARVALID only when ost<AMI_OD and resv+beats<=AMI_RD.
  - Once raised, ARVALID and AR fields hold until ARREADY.
  - On handshake: resv+=beats, ost+=1; push last_flag to tag FIFO (depth AMI_OD); addr+=beats<<L; rem-=beats.
  - Next state: IDLE if rem==0, else CALC.
  - Latency: request to first ARVALID is 2 cycles when credit is available.
- R path:
  - Every R handshake writes {id,RDATA,RRESP,RLAST&tag_head} to the R buffer.
  - On RLAST handshake: pop tag FIFO, ost-=1.
  - Each usr_rvalid&usr_rready pop: resv-=1.
  - Simultaneous AR issue and R-last/pop in one cycle: apply both deltas together.
  - resv counts beats reserved or buffered. Invariant: resv<=AMI_RD, so RREADY stays 1 while the slave returns only requested beats.
- Boundaries:
  - addr exactly 4 KB aligned gives to4k=256, capped by BL.
  - usr_arlen=0 gives one burst with ARLEN=0 and usr_rlast on that beat.
  - Maximum request 2^ULW beats: rem counter must not overflow.
  - addr wraps modulo 2^AXI_AW.
- usr_arready stays 0 from acceptance until the last sub-burst AR handshake. A new request may then overlap the returning data of the previous one.

Optional Feature:
- Macro: AMI_R_RESP_MERGE_EN.
- Defined:
  - A sticky register holds the worst RRESP (max value) seen in the current request.
  - usr_rresp shows the running worst value on each beat.
  - The register clears after the usr_rlast pop.
- Undefined: usr_rresp is the per-beat RRESP passthrough.

Test Plan:
- usr_araddr=0x0F80, usr_arlen=63, AXI_DW=128, BL=16 -> AR bursts (0xF80,7), (0x1000,15), (0x1100,15), (0x1200,15), (0x1300,7); 64 data beats; usr_rlast only on beat 64.
- usr_araddr=0x2000, usr_arlen=0 -> one AR (0x2000, ARLEN=0); one beat with usr_rlast=1; usr_arready returns 1 the cycle after handshake.
- AMI_RD=32, usr_rready=0, usr_arlen=63 at 0x0 -> exactly 2 ARs issued, ARVALID then stays 0; after 16 user pops the 3rd AR is issued; RREADY never deasserts.
- AMI_OD=2, slave delays R by 50 cycles, usr_arlen=63 -> at most 2 ARs outstanding; 3rd ARVALID rises only after the first RLAST.
- ARREADY held low 10 cycles during ISSUE -> ARVALID, ARADDR and ARLEN stable throughout; ARESET pulsed mid-burst -> ARVALID and usr_rvalid go 0 immediately, usr_arready=1 after release.
- Macro defined; beat 5 of 8 gets RRESP=2 -> usr_rresp=2 on beats 5–8; next request starts at 0.
